// File: rtl/conv_line_ctrl.sv
// conv_line_ctrl
// Line-buffer and window sequencer in front of the 3x3 Sobel convolution stage.
// Takes a raster-order pixel stream and keeps two line buffers. It presents the
// three vertically aligned taps for the incoming column, and it raises
// o_win_valid only when the 3x3 window behind those taps is complete.
//
// Ports:
//   i_clk              system clock
//   i_rst              synchronous reset, active low
//   i_in_valid         i_in_pixel is valid this cycle
//   i_in_sof           first pixel of a frame (qualified by i_in_valid)
//   i_in_pixel         raster pixel, line-major
//   o_row0_pixel       tap from line r-2 (oldest)
//   o_row1_pixel       tap from line r-1
//   o_row2_pixel       tap from line r (current pixel)
//   o_row2_pixel_edge  presented column is 0 or IMG_W-1
//   o_win_valid        3x3 window complete once this column is shifted in
//   o_busy             FSM in FILL or RUN
//   o_frame_done       one-cycle pulse after the last pixel of a frame
//   o_bubble_cnt       [CONV_LINE_CTRL_BUBBLE_CNT_EN only] count of input bubbles
//                      seen in FILL/RUN, saturating
//
// Build option: define CONV_LINE_CTRL_BUBBLE_CNT_EN to add o_bubble_cnt.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | wait for an in_sof pixel; all other pixels are dropped
// FILL  | lines 0..1 being loaded into the line buffers, no windows
// RUN   | lines 2..IMG_H-1, windows issued
// DONE  | one cycle after the last pixel; frame_done is raised next

module conv_line_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic             i_in_sof,
    input  logic [PIX_W-1:0] i_in_pixel,
    output logic [PIX_W-1:0] o_row0_pixel,
    output logic [PIX_W-1:0] o_row1_pixel,
    output logic [PIX_W-1:0] o_row2_pixel,
    output logic             o_row2_pixel_edge,
    output logic             o_win_valid,
    output logic             o_busy,
    output logic             o_frame_done
`ifdef CONV_LINE_CTRL_BUBBLE_CNT_EN
    ,
    output logic [15:0]      o_bubble_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [1:0]       r_run;
    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_row0;
    logic [PIX_W-1:0] r_row1;
    logic [PIX_W-1:0] r_row2;
    logic             r_edge;
    logic             r_win;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_active;
    logic             w_sof;
    logic             w_accept;
    logic [CW-1:0]    w_col_cur;
    logic [RW-1:0]    w_row_cur;
    logic             w_eol;
    logic             w_win;

    assign w_active = (r_state == S_FILL) || (r_state == S_RUN);
    // An accepted sof restarts the frame from IDLE, FILL or RUN; never in DONE.
    assign w_sof    = i_in_valid && i_in_sof && (w_active || (r_state == S_IDLE));
    assign w_accept = i_in_valid && (w_active || ((r_state == S_IDLE) && i_in_sof));

    // Position of the pixel being accepted this cycle; sof forces (0,0).
    assign w_col_cur = w_sof ? '0 : r_col;
    assign w_row_cur = w_sof ? '0 : r_row;
    assign w_eol     = (w_col_cur == COL_LAST);

    // r_run counts contiguous same-line pixels accepted so far (saturating at 2).
    // Once it reaches 2, the previous two clocks carried pixels of this line. A
    // bubble breaks the conv stage's shift chain, so the count must restart.
    assign w_win = w_accept && (r_state == S_RUN) && !w_sof &&
                   (w_col_cur >= CW'(2)) && (r_run == 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sof) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_sof)
                    w_state_nxt = S_FILL;
                else if (w_accept && w_eol && (w_row_cur == RW'(1)))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_sof)
                    w_state_nxt = S_FILL;
                else if (w_accept && w_eol && (w_row_cur == ROW_LAST))
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line buffers are not reset: the FILL lines overwrite them before use.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_lb0[w_col_cur] <= r_lb1[w_col_cur];
            r_lb1[w_col_cur] <= i_in_pixel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_run        <= 2'd0;
            r_row0       <= '0;
            r_row1       <= '0;
            r_row2       <= '0;
            r_edge       <= 1'b0;
            r_win        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);
            r_frame_done <= (r_state == S_DONE);
            r_win        <= w_win;

            if (w_accept) begin
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= (w_row_cur == ROW_LAST) ? '0 : w_row_cur + RW'(1);
                end else begin
                    r_col <= w_col_cur + CW'(1);
                    r_row <= w_row_cur;
                end

                if (w_col_cur == '0)
                    r_run <= 2'd1;
                else if (r_run != 2'd2)
                    r_run <= r_run + 2'd1;

                r_row0 <= r_lb0[w_col_cur];
                r_row1 <= r_lb1[w_col_cur];
                r_row2 <= i_in_pixel;
                r_edge <= (w_col_cur == '0) || w_eol;
            end else begin
                if ((r_state == S_RUN) && !i_in_valid)
                    r_run <= 2'd0;
                r_edge <= 1'b0;
            end
        end
    end

    assign o_row0_pixel      = r_row0;
    assign o_row1_pixel      = r_row1;
    assign o_row2_pixel      = r_row2;
    assign o_row2_pixel_edge = r_edge;
    assign o_win_valid       = r_win;
    assign o_busy            = r_busy;
    assign o_frame_done      = r_frame_done;

`ifdef CONV_LINE_CTRL_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_bubble_cnt <= 16'd0;
        else if (w_sof)
            r_bubble_cnt <= 16'd0;
        else if (w_active && !i_in_valid && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule
